// File: rtl/dice_pkg.sv
// Shared die encodings, controller FSM states and side-count helper for dice_roller
// and dice_roll_controller.
package dice_pkg;

    typedef enum logic [1:0] {
        D4  = 2'b00,
        D6  = 2'b01,
        D8  = 2'b10,
        D20 = 2'b11
    } die_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } ctrl_state_e;

    function automatic logic [7:0] die_sides(input die_e die);
        case (die)
            D4:      return 8'd4;
            D6:      return 8'd6;
            D8:      return 8'd8;
            default: return 8'd20;
        endcase
    endfunction

endpackage

// File: rtl/dice_roll_accum.sv
// Sum/min/max accumulator for sampled rolls. With DICE_RANGE_CHECK_EN defined, an
// out-of-range sample sets a sticky roll_err; otherwise roll_err is tied low.
module dice_roll_accum
    import dice_pkg::*;
#(
    parameter int SUM_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_zero_min,
    input  logic             i_sample,
`ifdef DICE_RANGE_CHECK_EN
    input  die_e             i_die,
`endif
    input  logic [7:0]       i_value,
    output logic [SUM_W-1:0] o_sum,
    output logic [7:0]       o_min,
    output logic [7:0]       o_max,
    output logic             o_roll_err
);

    logic [SUM_W-1:0] r_sum;
    logic [7:0]       r_min;
    logic [7:0]       r_max;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sum <= '0;
            r_min <= '0;
            r_max <= '0;
        end else if (i_clear) begin
            // An empty request reports min as 0 rather than the FF seed.
            r_sum <= '0;
            r_min <= i_zero_min ? 8'h00 : 8'hFF;
            r_max <= '0;
        end else if (i_sample) begin
            r_sum <= r_sum + SUM_W'(i_value);
            if (i_value < r_min) r_min <= i_value;
            if (i_value > r_max) r_max <= i_value;
        end
    end

`ifdef DICE_RANGE_CHECK_EN
    logic r_roll_err;
    logic w_out_of_range;

    assign w_out_of_range = (i_value == 8'd0) || (i_value > die_sides(i_die));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_roll_err <= 1'b0;
        end else if (i_clear) begin
            r_roll_err <= 1'b0;
        end else if (i_sample && w_out_of_range) begin
            r_roll_err <= 1'b1;
        end
    end

    assign o_roll_err = r_roll_err;
`else
    assign o_roll_err = 1'b0;
`endif

    assign o_sum = r_sum;
    assign o_min = r_min;
    assign o_max = r_max;

endmodule

// File: rtl/dice_roll_controller.sv
// Sequences N roll/settle/sample cycles against a dice_roller and reports sum/min/max
// with a done pulse. DICE_RANGE_CHECK_EN enables the sticky roll_err range check.
module dice_roll_controller
    import dice_pkg::*;
#(
    parameter int ROLL_HOLD_CYCLES = 10,
    parameter int SETTLE_CYCLES    = 2,
    parameter int CNT_W            = 4,
    parameter int SUM_W            = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_die,
    input  logic [CNT_W-1:0] req_count,
    output logic [1:0]       die_select,
    output logic             roll,
    input  logic [7:0]       rolled_number,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sum,
    output logic [7:0]       min_val,
    output logic [7:0]       max_val,
    output logic             roll_err
);

    localparam int TMR_MAX = (ROLL_HOLD_CYCLES > SETTLE_CYCLES) ? ROLL_HOLD_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    ctrl_state_e      r_state;
    ctrl_state_e      w_state_next;
    logic [TMR_W-1:0] r_timer;
    logic [CNT_W-1:0] r_remaining;
    die_e             r_die;
    logic             r_roll;
    logic             r_done;

    logic w_accept;
    logic w_start_hold;
    logic w_start_settle;
    logic w_sample;
    logic w_zero_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_start_hold   = 1'b0;
        w_start_settle = 1'b0;
        w_sample       = 1'b0;
        w_zero_count   = (req_count == '0);
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (w_zero_count) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_HOLD;
                        w_start_hold = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (r_timer == '0) begin
                    w_state_next   = S_SETTLE;
                    w_start_settle = 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_timer == '0) w_state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                w_sample = 1'b1;
                if (r_remaining == CNT_W'(1)) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_HOLD;
                    w_start_hold = 1'b1;
                end
            end
            S_DONE: begin
                // DONE lingers until the pulse has been emitted; a zero-count request
                // spends its first DONE cycle with done still low.
                if (r_done) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer     <= '0;
            r_remaining <= '0;
            r_die       <= D4;
            r_roll      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state != S_IDLE) && (w_state_next == S_DONE) && !r_done;
            if (w_accept) begin
                r_die       <= die_e'(req_die);
                r_remaining <= req_count;
            end
            if (w_sample) r_remaining <= r_remaining - CNT_W'(1);
            if (w_start_hold) begin
                r_timer <= TMR_W'(ROLL_HOLD_CYCLES - 1);
                r_roll  <= 1'b1;
            end else if (w_start_settle) begin
                r_timer <= TMR_W'(SETTLE_CYCLES - 1);
                r_roll  <= 1'b0;
            end else if (r_timer != '0) begin
                r_timer <= r_timer - TMR_W'(1);
            end
        end
    end

    dice_roll_accum #(
        .SUM_W(SUM_W)
    ) u_accum (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_clear    (w_accept),
        .i_zero_min (w_zero_count),
        .i_sample   (w_sample),
`ifdef DICE_RANGE_CHECK_EN
        .i_die      (r_die),
`endif
        .i_value    (rolled_number),
        .o_sum      (sum),
        .o_min      (min_val),
        .o_max      (max_val),
        .o_roll_err (roll_err)
    );

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = !req_ready;
    assign done       = r_done;
    assign roll       = r_roll;
    assign die_select = r_die;

endmodule
